// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer with imem handshake, redirect, halt and timeout fault
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] link_addr,
  output logic        busy,
  output logic        fault
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;
  localparam logic [1:0] S_FAULT   = 2'd3;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_tgt;
  logic [31:0]   r_instr;
  logic [31:0]   r_fetch_pc;
  logic          r_valid;
  logic          r_fault;
  logic          r_kill;
  logic          r_halt_pend;
  logic [CW-1:0] r_cnt;
  logic          w_bad;
  logic          w_stop;

  assign w_bad       = redirect && (redirect_target[1:0] != 2'b00);
  assign w_stop      = r_halt_pend || halt;
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign fetch_pc    = r_fetch_pc;
  assign link_addr   = r_fetch_pc + 32'd4;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DELIVER);
  assign fault       = r_fault;

  // Fetch FSM: the PC stays stable while a request is outstanding, so a redirect
  // arriving mid-request is parked in r_tgt and applied when the ack retires it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_tgt       <= '0;
      r_instr     <= '0;
      r_fetch_pc  <= '0;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_kill      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_pc    <= RESET_VECTOR;
          r_cnt   <= '0;
          r_kill  <= 1'b0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (halt) r_halt_pend <= 1'b1;
          if (w_bad) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else if (imem_ack && (r_kill || redirect)) begin
            r_pc   <= redirect ? redirect_target : r_tgt;
            r_kill <= 1'b0;
            r_cnt  <= '0;
          end else if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_fetch_pc <= r_pc;
            r_valid    <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_DELIVER;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (redirect) begin
              r_kill <= 1'b1;
              r_tgt  <= redirect_target;
            end
          end
        end
        S_DELIVER: begin
          if (w_bad) begin
            r_valid <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else if (redirect || instr_ready) begin
            r_valid     <= 1'b0;
            r_pc        <= redirect ? redirect_target : r_pc + 32'd4;
            r_halt_pend <= 1'b0;
            r_cnt       <= '0;
            r_state     <= w_stop ? S_IDLE : S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
